imm_ext_arbiter: RTL

IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

---
 rtl/imm_ext_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imm_ext_arbiter.sv
// ---------------------------------------------------------------------------
// imm_ext_arbiter : round-robin two-requester immediate extender, 2-stage pipe
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imm_ext_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_instr,
  input  logic [2:0]  req0_fmt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_instr,
  input  logic [2:0]  req1_fmt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_imm,
  output logic        out_id,
  output logic        out_err
);

  localparam logic [2:0] C_FMT_I12  = 3'd0;
  localparam logic [2:0] C_FMT_S9   = 3'd1;
  localparam logic [2:0] C_FMT_B19  = 3'd2;
  localparam logic [2:0] C_FMT_J26  = 3'd3;
  localparam logic [2:0] C_FMT_U6   = 3'd4;
  localparam logic [2:0] C_FMT_MOVW = 3'd5;

  logic        r_run;
  logic        r_ptr;
  logic        r_s1_valid;
  logic [25:0] r_s1_instr;
  logic [2:0]  r_s1_fmt;
  logic        r_s1_id;
  logic        r_s2_valid;
  logic [63:0] r_s2_imm;
  logic        r_s2_id;
  logic        r_s2_err;

  logic        w_s2_free;
  logic        w_s1_free;
  logic        w_s1_adv;
  logic        w_gnt_valid;
  logic        w_gnt_id;
  logic        w_accept;
  logic [31:0] w_gnt_instr;
  logic [2:0]  w_gnt_fmt;
  logic [63:0] w_ext_imm;
  logic        w_ext_err;
  logic        w_unused;

  // Upper instruction bits never feed any format.
  assign w_unused = ^{req0_instr[31:26], req1_instr[31:26]};

  // r_run holds ready low until the first edge after reset release.
  assign w_s2_free = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign w_s1_free = r_run && (!r_s1_valid || w_s2_free);

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_valid = 1'b1;
      w_gnt_id    = ~r_ptr;
    end else if (req0_valid) begin
      w_gnt_valid = 1'b1;
      w_gnt_id    = 1'b0;
    end else if (req1_valid) begin
      w_gnt_valid = 1'b1;
      w_gnt_id    = 1'b1;
    end
  end

  assign w_accept    = w_s1_free && w_gnt_valid;
  assign req0_ready  = w_accept && !w_gnt_id;
  assign req1_ready  = w_accept && w_gnt_id;
  assign w_gnt_instr = w_gnt_id ? req1_instr : req0_instr;
  assign w_gnt_fmt   = w_gnt_id ? req1_fmt : req0_fmt;

  always_comb begin
    w_ext_imm = 64'd0;
    w_ext_err = 1'b0;
    case (r_s1_fmt)
      C_FMT_I12:  w_ext_imm = {52'd0, r_s1_instr[21:10]};
      C_FMT_S9:   w_ext_imm = {{55{r_s1_instr[20]}}, r_s1_instr[20:12]};
      C_FMT_B19:  w_ext_imm = {{43{r_s1_instr[23]}}, r_s1_instr[23:5], 2'b00};
      C_FMT_J26:  w_ext_imm = {{36{r_s1_instr[25]}}, r_s1_instr[25:0], 2'b00};
      C_FMT_U6:   w_ext_imm = {58'd0, r_s1_instr[15:10]};
      C_FMT_MOVW: w_ext_imm = {48'd0, r_s1_instr[20:5]} << {r_s1_instr[22:21], 4'b0000};
      default:    w_ext_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run      <= 1'b0;
      r_ptr      <= 1'b1;
      r_s1_valid <= 1'b0;
      r_s1_instr <= 26'd0;
      r_s1_fmt   <= 3'd0;
      r_s1_id    <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_imm   <= 64'd0;
      r_s2_id    <= 1'b0;
      r_s2_err   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        r_ptr      <= w_gnt_id;
        r_s1_instr <= w_gnt_instr[25:0];
        r_s1_fmt   <= w_gnt_fmt;
        r_s1_id    <= w_gnt_id;
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      // S2 payload only changes on advance, so it stays stable under stall.
      if (w_s1_adv) begin
        r_s2_imm   <= w_ext_imm;
        r_s2_id    <= r_s1_id;
        r_s2_err   <= w_ext_err;
        r_s2_valid <= 1'b1;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_imm   = r_s2_imm;
  assign out_id    = r_s2_id;
  assign out_err   = r_s2_err;

endmodule

`default_nettype wire
